// File: rtl/mux_2to1.sv
// Registered 2:1 word multiplexer with asynchronous active-high reset.
// Define MUX_2TO1_COMB_OUT_EN to build a purely combinational mux that ignores clk and rst.
module mux_2to1 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] nxt;

    assign nxt = sel ? in1 : in0;

`ifdef MUX_2TO1_COMB_OUT_EN

    assign out = nxt;

    // The combinational build has no state, so the clock and reset are
    // intentionally left unconnected.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

`else

    // NOTE: non-blocking assignment keeps the register's update ordered
    // after every reader of the old value in the same time step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= nxt;
        end
    end

`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Directed self-checking bench for mux_2to1 (WIDTH=32).
// Honours MUX_2TO1_COMB_OUT_EN so the same vectors cover both builds.
module tb_mux_2to1;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] out;

    int n_checks;
    int n_fail;

    mux_2to1 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .in0 (in0),
        .in1 (in1),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        logic [WIDTH-1:0] exp;
`ifdef MUX_2TO1_COMB_OUT_EN
        exp = 32'd9;
`else
        exp = 32'd0;
`endif
        // Before the first clock edge at t=5.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out !== exp) begin
            n_fail++;
            $display("FAIL reset_async: out=%h expected=%h", out, exp);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, out, exp);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'd9) begin
            n_fail++;
            $display("FAIL reset_first_load: out=%h expected=%h", out, 32'd9);
        end
    endtask

    task automatic test_select0;
        logic [WIDTH-1:0] exp_pre;
        @(negedge clk);
        sel = 1'b0;
        in0 = 32'd2;
        in1 = 32'd1;
        #1;
`ifdef MUX_2TO1_COMB_OUT_EN
        exp_pre = 32'd2;
`else
        exp_pre = 32'd9;
`endif
        n_checks++;
        if (out !== exp_pre) begin
            n_fail++;
            $display("FAIL select0_pre_edge: out=%h expected=%h", out, exp_pre);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'd2) begin
            n_fail++;
            $display("FAIL select0: out=%h expected=%h", out, 32'd2);
        end
    endtask

    task automatic test_select1;
        @(negedge clk);
        sel = 1'b1;
        in0 = 32'd1;
        in1 = 32'd4;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'd4) begin
            n_fail++;
            $display("FAIL select1: out=%h expected=%h", out, 32'd4);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        sel = 1'b0;
        in0 = 32'd7;
        in1 = 32'd3;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'd7) begin
            n_fail++;
            $display("FAIL b2b_sel0: out=%h expected=%h", out, 32'd7);
        end
        @(negedge clk);
        sel = 1'b1;
        in0 = 32'd0;
        in1 = 32'd6;
        // Hold inputs stable for four edges (40 time units).
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out !== 32'd6) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: out=%h expected=%h", i, out, 32'd6);
            end
        end
    endtask

    task automatic test_full_width;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        in0 = 32'h0000_0000;
        in1 = 32'hFFFF_FFFF;
        sel = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            @(posedge clk);
            #1;
            n_checks++;
            if (out !== exp) begin
                n_fail++;
                $display("FAIL full_width[%0d]: out=%h expected=%h", i, out, exp);
            end
            @(negedge clk);
            sel = ~sel;
        end
    endtask

    task automatic test_equal_inputs;
        @(negedge clk);
        in0 = 32'hA5A5_5A5A;
        in1 = 32'hA5A5_5A5A;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            sel = i[0];
            @(posedge clk);
            #1;
            n_checks++;
            if (out !== 32'hA5A5_5A5A) begin
                n_fail++;
                $display("FAIL equal_inputs[sel=%0d]: out=%h expected=%h", i, out, 32'hA5A5_5A5A);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [WIDTH-1:0] exp_rst;
        @(negedge clk);
        sel = 1'b0;
        in0 = 32'd11;
        in1 = 32'd22;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'd11) begin
            n_fail++;
            $display("FAIL mid_reset_stream: out=%h expected=%h", out, 32'd11);
        end
        // New pending value, then reset before it can be loaded.
        @(negedge clk);
        in0 = 32'd33;
        #2;
        rst = 1'b1;
        #1;
`ifdef MUX_2TO1_COMB_OUT_EN
        exp_rst = 32'd33;
`else
        exp_rst = 32'd0;
`endif
        n_checks++;
        if (out !== exp_rst) begin
            n_fail++;
            $display("FAIL mid_reset_async: out=%h expected=%h", out, exp_rst);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== exp_rst) begin
            n_fail++;
            $display("FAIL mid_reset_edge: out=%h expected=%h", out, exp_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 1'b1;
        in1 = 32'd44;
        @(posedge clk);
        #1;
        n_checks++;
        if (out !== 32'd44) begin
            n_fail++;
            $display("FAIL mid_reset_release: out=%h expected=%h", out, 32'd44);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        sel = 1'b1;
        in0 = 32'd5;
        in1 = 32'd9;

        test_reset();
        test_select0();
        test_select1();
        test_back_to_back();
        test_full_width();
        test_equal_inputs();
        test_mid_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
